// File: rtl/merge_channels_rr_pkg.sv
// Shared definitions for the round-robin channel merge: channel limits,
// burst counter width and the rotating grant picker.
package merge_channels_rr_pkg;

    localparam int MAX_CH  = 16;
    localparam int IDX_W   = 4;
    localparam int BURST_W = 8;
    localparam logic [BURST_W-1:0] BURST_SAT = 8'd255;

    // One-hot grant for the first valid channel after `last`, wrapping modulo m.
    // Lands on `last` itself only when it is the sole valid channel.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                                  input logic [IDX_W-1:0]  last,
                                                  input int                m);
        logic [MAX_CH-1:0] grant;
        logic              found;
        int                idx;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = (int'(last) + i) % m;
            if ((i <= m) && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/merge_channels_rr_slice.sv
// One-entry registered channel stage: owns the full flag, the load decision
// and the ready term that gates upstream acknowledges.
module merge_channels_rr_slice #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_d,
    input  logic         in_v,
    output logic         in_ready,
    output logic         load,
    output logic [W-1:0] out_d,
    output logic         out_v,
    input  logic         out_a
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Ready drops during reset so no producer sees an acknowledge it cannot complete.
    assign in_ready = ~reset & (~full_q | out_a);
    assign load     = in_v & in_ready;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = in_d;
        end else if (out_a) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_v = full_q;
    assign out_d = data_q;

endmodule

// File: rtl/merge_channels_rr.sv
// M-way round-robin merge with burst hold onto one registered output channel;
// out_src tags which input produced the word currently on out_d.
module merge_channels_rr
    import merge_channels_rr_pkg::*;
#(
    parameter  int N        = 16,
    parameter  int M        = 4,
    parameter  int BurstMax = 1,
    localparam int SrcW     = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [M*N-1:0]  in_d,
    input  logic [M-1:0]    in_v,
    output logic [M-1:0]    in_a,
    output logic [N-1:0]    out_d,
    output logic            out_v,
    input  logic            out_a,
    output logic [SrcW-1:0] out_src
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BurstMax);

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        return (v == BURST_SAT) ? BURST_SAT : v + 1'b1;
    endfunction

    logic [SrcW-1:0]    last_q, last_d, winner;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [M-1:0]       grant;
    logic               hold, slot_ready, load;
    logic [N+SrcW-1:0]  slot_in, slot_out;

    // A zero count means nothing has been granted since reset, so rotation
    // (starting after last = M-1) picks the first winner rather than a hold.
    always_comb begin
        hold   = in_v[last_q] && (burst_cnt_q != '0) && (burst_cnt_q < BURST_MAX);
        grant  = '0;
        if (hold) begin
            grant[last_q] = 1'b1;
        end else begin
            grant = M'(rr_pick(MAX_CH'(in_v), IDX_W'(last_q), M));
        end
        winner = '0;
        for (int i = 0; i < M; i++) begin
            if (grant[i]) winner = SrcW'(i);
        end
    end

    assign in_a    = grant & {M{slot_ready}};
    assign slot_in = {in_d[winner*N +: N], winner};

    always_comb begin
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (load) begin
            last_d      = winner;
            burst_cnt_d = (winner == last_q) ? sat_inc(burst_cnt_q) : BURST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= SrcW'(M - 1);
            burst_cnt_q <= '0;
        end else begin
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Output register stage
    merge_channels_rr_slice #(.W(N + SrcW)) u_slice (
        .clk      (clk),
        .reset    (reset),
        .in_d     (slot_in),
        .in_v     (|in_v),
        .in_ready (slot_ready),
        .load     (load),
        .out_d    (slot_out),
        .out_v    (out_v),
        .out_a    (out_a)
    );

    assign out_d   = slot_out[N+SrcW-1:SrcW];
    assign out_src = slot_out[SrcW-1:0];

endmodule

// File: tb/tb_merge_channels_rr.sv
// Directed bench for merge_channels_rr: pure round-robin, burst hold, lone
// input streaming, backpressure and reset in the middle of a stream.
module tb_merge_channels_rr;

    logic        clk;
    logic        reset;
    logic [63:0] in_d1, in_d3;
    logic [3:0]  in_v1, in_v3, in_a1, in_a3;
    logic [15:0] out_d1, out_d3;
    logic        out_v1, out_v3, out_a1, out_a3;
    logic [1:0]  out_src1, out_src3;
    logic [11:0] cnt [4];

    int checks = 0;
    int errors = 0;

    merge_channels_rr #(.N(16), .M(4), .BurstMax(1)) dut1 (
        .clk(clk), .reset(reset), .in_d(in_d1), .in_v(in_v1), .in_a(in_a1),
        .out_d(out_d1), .out_v(out_v1), .out_a(out_a1), .out_src(out_src1)
    );

    merge_channels_rr #(.N(16), .M(4), .BurstMax(3)) dut3 (
        .clk(clk), .reset(reset), .in_d(in_d3), .in_v(in_v3), .in_a(in_a3),
        .out_d(out_d3), .out_v(out_v3), .out_a(out_a3), .out_src(out_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producers for dut1: word = {channel, sequence number}, advanced on acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (in_a1[i]) cnt[i] <= cnt[i] + 12'd1;
        end
    end

    always_comb begin
        in_d1 = '0;
        for (int i = 0; i < 4; i++) in_d1[i*16 +: 16] = {4'(i), cnt[i]};
    end

    assign in_d3 = {4{16'hA5A5}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        in_v1  = 4'hF;
        in_v3  = 4'hF;
        out_a1 = 1'b0;
        out_a3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_v",   32'(out_v1),   0);
        check("rst_out_d",   32'(out_d1),   0);
        check("rst_out_src", 32'(out_src1), 0);
        check("rst_in_a",    32'(in_a1),    0);
        check("rst_out_v3",  32'(out_v3),   0);

        reset  = 1'b0;
        out_a1 = 1'b1;
        out_a3 = 1'b1;
        #1;
        check("first_in_a",  32'(in_a1),  32'h1);
        check("first_out_v", 32'(out_v1), 0);
        check("first_in_a3", 32'(in_a3),  32'h1);

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check("rr_v",      32'(out_v1),   1);
            check("rr_src",    32'(out_src1), k % 4);
            check("rr_d",      32'(out_d1),   ((k % 4) << 12) | (k / 4));
            check("rr_in_a",   32'(in_a1),    1 << ((k + 1) % 4));
            check("burst_src", 32'(out_src3), (k / 3) % 4);
        end
        check("burst_d", 32'(out_d3), 32'hA5A5);

        // Reset while the slot is full: output must drop without a clock edge.
        check("mid_full", 32'(out_v1), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_out_v",  32'(out_v1),   0);
        check("mid_out_v3", 32'(out_v3),   0);
        check("mid_out_d",  32'(out_d1),   0);
        check("mid_src",    32'(out_src1), 0);
        check("mid_in_a",   32'(in_a1),    0);

        in_v1 = 4'b0100;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("lone_in_a", 32'(in_a1), 32'h4);

        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("lone_v",   32'(out_v1),   1);
            check("lone_src", 32'(out_src1), 2);
            check("lone_d",   32'(out_d1),   32'h2000 | j);
            if (j < 4) check("restart_src3", 32'(out_src3), (j == 3) ? 1 : 0);
        end

        out_a1 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("bp_in_a", 32'(in_a1),    0);
            check("bp_v",    32'(out_v1),   1);
            check("bp_d",    32'(out_d1),   32'h2013);
            check("bp_src",  32'(out_src1), 2);
        end

        out_a1 = 1'b1;
        @(negedge clk);
        check("rel_d0", 32'(out_d1), 32'h2014);
        @(negedge clk);
        check("rel_d1", 32'(out_d1), 32'h2015);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/merge_channels_rr.md
# merge_channels_rr

Parametrised M-way merge of valid/acknowledge `Channel` streams onto one output `Channel`. It replaces the two-input merge wherever more than two producers share a sink, e.g. the FPGA upstream path that funnels several decoders into one serializer. Arbitration is round-robin with an optional burst hold. The output is registered, which breaks the timing path at full throughput, and a source tag identifies the winning input.

## Interface
Parameters:
- `N`, 16: data width of every input and the output.
- `M`, 4: number of input channels, 2..16.
- `BurstMax`, 1: maximum consecutive grants to one input before the pointer must rotate. 1 gives pure round-robin. Range 1..255.
- `SrcW`, `$clog2(M)`: width of the source tag (derived; do not override).

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high.
- `in`  ChannelArray `#(N, M)`  inputs.
  - `in.d[i]`, `in.v[i]` are driven by producer i.
  - `in.a[i]` is driven by this block, combinationally.
- `out`  Channel `#(N)`  merged output.
  - `out.d`, `out.v` are registered.
  - `out.a` is driven by the sink, combinationally.
- `out_src`  out  SrcW  index of the input that produced the current `out.d`; valid whenever `out.v`=1.

## Operation
- Output slot: one register holding `{d, src}` plus `full`. `out.v = full`.
- `load = |in.v & (~full | out.a)`.
  - If `load`=1, the slot captures the winner on the next posedge.
  - If `~load & out.a`, the slot empties.
- Acknowledge: `in.a[i] = grant[i] & (~full | out.a)`.
  - Exactly one `in.a` is high per transfer, and none when no input is valid.
  - `in.a` never depends on `in.d`.
- Grant selection (combinational, one-hot, only among `in.v`=1):
  1. **Hold:** if `in.v[last]`=1 and `burst_cnt < BurstMax`, grant `last`.
  2. **Rotate:** otherwise grant the first valid input scanning `last+1, last+2, ...` modulo M. This scan may land on `last` itself if it is the only valid input.
- State update on each `load`:
  - `last <= winner`.
  - `burst_cnt <= (winner == last) ? burst_cnt+1 : 1`.
  - `burst_cnt` saturates at 255.
  - With no `load`, `last` and `burst_cnt` hold.
- A lone valid input is never starved or throttled: the burst limit only forces rotation when another input is valid.
- Fairness: with all M inputs continuously valid and `out.a` held high, input i receives exactly `BurstMax` consecutive grants, then input i+1 (mod M) does.
- Inputs must obey the channel rule: once `in.v[i]` rises it stays high with stable `in.d[i]` until `in.a[i]`. The block does not check this.

## Timing
- Reset values:
  - `out.v`=0, `out.d`=0, `out_src`=0.
  - `full`=0, `burst_cnt`=0.
  - `last`=M-1, so input 0 wins first.
  - All `in.a`=0 while `reset`=1.
- Latency: an input accepted at posedge k appears on `out` from posedge k+1.
- Throughput: one word per cycle when `out.a` is held high.
- Path: `out.a` → `in.a` is combinational (one AND).
- Backpressure (`full`=1 and `out.a`=0):
  - all `in.a`=0;
  - `out.d` and `out_src` stay stable;
  - arbitration state holds.
- Simultaneous drain and fill (`out.a`=1 with an input valid): the slot reloads in the same cycle with no bubble.
- Reset mid-transfer: the slot content is discarded, `out.v` drops asynchronously, and arbitration restarts from input 0.

## Structure
- The shared `ChannelPkg` package adds `function automatic rr_pick(valid, last, M)`, which returns the one-hot grant by rotation. The two-input merge may reuse it.
- Sub-module `ChannelRegSlice #(N+SrcW)`: a one-entry registered channel stage that owns `full`, `load` and the `in.a` gating. It is reusable standalone as a pipeline stage. The arbiter and burst counter stay in the top module.

## Test plan
- **Reset and first grant:** reset, then M=4, `BurstMax`=1, all inputs valid, `out.a`=1 → `out_src` sequence is 0,1,2,3,0,...; first `out.v` one cycle after the first `in.a[0]`.
- **Burst hold:** M=4, `BurstMax`=3, all valid, sink always ready → `out_src` is 0,0,0,1,1,1,2,2,2,3,3,3,0.
- **Lone input:** only input 2 valid with a 20-word stream, `BurstMax`=1 → 20 consecutive outputs with `out_src`=2, no bubbles, data in order.
- **Backpressure:** hold `out.a`=0 for 5 cycles with the slot full → all `in.a`=0 and `out.d`/`out_src` constant. On release, the next word follows the held word with no gap and no loss.
- **Random soak:** `RandomChannelSrc` on each of 8 inputs (delays 0..5) and a `ChannelSink` with random ready, 10k words.
  - Per-input scoreboard: every word arrives exactly once, in order, with the correct `out_src`.
  - No input waits more than `(M-1)*BurstMax` grants while valid.
- **Reset mid-stream:** assert `reset` while `full`=1 → `out.v`=0 immediately. After release, arbitration restarts at input 0.
